// File: rtl/stream_max_pool.sv
// Streaming non-overlapping KxK max-pool over a raster pixel stream with valid/ready
// handshakes. It keeps one running-max line buffer entry per output column.
module stream_max_pool #(
    parameter int ROWS        = 27,
    parameter int COLS        = 27,
    parameter int CHANNELS    = 1,
    parameter int KERNEL_ROWS = 2,
    parameter int KERNEL_COLS = 2,
    parameter int DATA_SIZE   = 8,
    parameter int RELU        = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHANNELS*DATA_SIZE-1:0] in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [CHANNELS*DATA_SIZE-1:0] out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          frame_done
);
    localparam int W        = CHANNELS * DATA_SIZE;
    localparam int OUT_ROWS = ROWS / KERNEL_ROWS;
    localparam int OUT_COLS = COLS / KERNEL_COLS;
    localparam int RW       = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW       = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int KRW      = (KERNEL_ROWS > 1) ? $clog2(KERNEL_ROWS) : 1;
    localparam int KCW      = (KERNEL_COLS > 1) ? $clog2(KERNEL_COLS) : 1;
    localparam int AW       = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;

    localparam logic [RW-1:0]  ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0]  COL_LAST = CW'(COLS - 1);
    localparam logic [KRW-1:0] KR_LAST  = KRW'(KERNEL_ROWS - 1);
    localparam logic [KCW-1:0] KC_LAST  = KCW'(KERNEL_COLS - 1);
    localparam logic [AW-1:0]  WC_LAST  = AW'(OUT_COLS - 1);

    logic [RW-1:0]  r;
    logic [CW-1:0]  c;
    logic [KRW-1:0] kr;
    logic [KCW-1:0] kc;
    logic [AW-1:0]  wc;

    logic           in_xfer;
    logic           in_window;
    logic           window_start;
    logic           window_last;
    logic [W-1:0]   acc [OUT_COLS];
    logic [W-1:0]   acc_rd;
    logic [W-1:0]   merged;
    logic [W-1:0]   result;

    assign in_ready     = !out_valid || out_ready;
    assign in_xfer      = in_valid && in_ready;
    assign in_window    = (int'(r) < OUT_ROWS * KERNEL_ROWS) && (int'(c) < OUT_COLS * KERNEL_COLS);
    assign window_start = (kr == '0) && (kc == '0);
    assign window_last  = (kr == KR_LAST) && (kc == KC_LAST);
    assign acc_rd       = acc[wc];

    // Each channel lane is pooled on its own; a window start replaces the running max.
    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_lane
        logic signed [DATA_SIZE-1:0] a;
        logic signed [DATA_SIZE-1:0] p;
        logic signed [DATA_SIZE-1:0] m;
        logic signed [DATA_SIZE-1:0] mg;

        assign a  = acc_rd[ch*DATA_SIZE +: DATA_SIZE];
        assign p  = in_data[ch*DATA_SIZE +: DATA_SIZE];
        assign m  = (a > p) ? a : p;
        assign mg = window_start ? p : m;
        assign merged[ch*DATA_SIZE +: DATA_SIZE] = mg;
        assign result[ch*DATA_SIZE +: DATA_SIZE] = (RELU != 0 && mg[DATA_SIZE-1]) ? '0 : mg;
    end

    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r          <= '0;
            c          <= '0;
            kr         <= '0;
            kc         <= '0;
            wc         <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= in_xfer && (r == ROW_LAST) && (c == COL_LAST);
            if (in_xfer) begin
                if (c == COL_LAST) begin
                    c  <= '0;
                    kc <= '0;
                    wc <= '0;
                    if (r == ROW_LAST) begin
                        r  <= '0;
                        kr <= '0;
                    end else begin
                        r  <= r + 1'b1;
                        kr <= (kr == KR_LAST) ? '0 : kr + 1'b1;
                    end
                end else begin
                    c <= c + 1'b1;
                    if (kc == KC_LAST) begin
                        kc <= '0;
                        // wc parks on the last window so trailing columns never index past acc.
                        if (wc != WC_LAST) wc <= wc + 1'b1;
                    end else begin
                        kc <= kc + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_xfer && in_window && window_last) begin
            out_valid <= 1'b1;
            out_data  <= result;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // NOTE: the line buffer is deliberately not reset; every window start overwrites its slot before it is read.
    always_ff @(posedge clk) begin
        if (in_xfer && in_window) acc[wc] <= merged;
    end

endmodule

// File: tb/tb_stream_max_pool.sv
// Randomized scoreboard bench: two pooling configurations share one 5x7 input stream
// and are compared against a window-max reference model built from the stored frame.
module tb_stream_max_pool;
    localparam int ROWS = 5;
    localparam int COLS = 7;
    localparam int CH   = 3;
    localparam int DS   = 8;
    localparam int W    = CH * DS;
    localparam int KR_A = 2, KC_A = 2, RELU_A = 0;
    localparam int KR_B = 3, KC_B = 2, RELU_B = 1;
    localparam int NPIX = ROWS * COLS;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         out_ready;
    logic         in_ready_a, out_valid_a, frame_done_a;
    logic [W-1:0] out_data_a;
    logic         in_valid_b, in_ready_b, out_valid_b, frame_done_b;
    logic         out_ready_b;
    logic [W-1:0] out_data_b;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] frame_px [ROWS][COLS];
    logic [W-1:0] qa [$];
    logic [W-1:0] qb [$];
    int           mr, mc;
    logic         fd_exp;

    always #5 clk = ~clk;

    // Config B only sees pixels that config A accepts; its output is never stalled.
    assign in_valid_b  = in_valid && in_ready_a;
    assign out_ready_b = 1'b1;

    stream_max_pool #(
        .ROWS(ROWS), .COLS(COLS), .CHANNELS(CH), .KERNEL_ROWS(KR_A),
        .KERNEL_COLS(KC_A), .DATA_SIZE(DS), .RELU(RELU_A)
    ) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready),
        .frame_done(frame_done_a)
    );

    stream_max_pool #(
        .ROWS(ROWS), .COLS(COLS), .CHANNELS(CH), .KERNEL_ROWS(KR_B),
        .KERNEL_COLS(KC_B), .DATA_SIZE(DS), .RELU(RELU_B)
    ) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .frame_done(frame_done_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Max over a whole window read straight from the stored frame, per signed lane.
    function automatic logic [W-1:0] pool(input int r0, input int c0, input int kr, input int kc,
                                          input bit relu);
        logic [W-1:0]   res;
        logic signed [DS-1:0] m, v;
        for (int ch = 0; ch < CH; ch++) begin
            m = frame_px[r0][c0][ch*DS +: DS];
            for (int i = 0; i < kr; i++)
                for (int j = 0; j < kc; j++) begin
                    v = frame_px[r0+i][c0+j][ch*DS +: DS];
                    if (v > m) m = v;
                end
            if (relu && m < 0) m = '0;
            res[ch*DS +: DS] = m;
        end
        return res;
    endfunction

    task automatic model_accept(input logic [W-1:0] d);
        frame_px[mr][mc] = d;
        if (mr < (ROWS/KR_A)*KR_A && mc < (COLS/KC_A)*KC_A && mr % KR_A == KR_A-1 && mc % KC_A == KC_A-1)
            qa.push_back(pool(mr-KR_A+1, mc-KC_A+1, KR_A, KC_A, RELU_A != 0));
        if (mr < (ROWS/KR_B)*KR_B && mc < (COLS/KC_B)*KC_B && mr % KR_B == KR_B-1 && mc % KC_B == KC_B-1)
            qb.push_back(pool(mr-KR_B+1, mc-KC_B+1, KR_B, KC_B, RELU_B != 0));
        if (mr == ROWS-1 && mc == COLS-1) fd_exp = 1'b1;
        mc++;
        if (mc == COLS) begin
            mc = 0;
            mr = (mr == ROWS-1) ? 0 : mr + 1;
        end
    endtask

    // Monitor: outputs are compared against the queue heads, then the accepted input feeds the model.
    always @(negedge clk) begin
        logic exp_rdy;
        if (rst) begin
            qa.delete();
            qb.delete();
            mr     = 0;
            mc     = 0;
            fd_exp = 1'b0;
        end else begin
            exp_rdy = !out_valid_a || out_ready;
            check("in_ready_a", in_ready_a, exp_rdy);
            check("in_ready_b", in_ready_b, 1);
            check("frame_done_a", frame_done_a, fd_exp);
            check("frame_done_b", frame_done_b, fd_exp);
            fd_exp = 1'b0;
            if (out_valid_a) begin
                if (qa.size() == 0) fail_now("unexpected_out_a");
                else begin
                    check("out_data_a", out_data_a, qa[0]);
                    if (out_ready) void'(qa.pop_front());
                end
            end
            if (out_valid_b) begin
                if (qb.size() == 0) fail_now("unexpected_out_b");
                else begin
                    check("out_data_b", out_data_b, qb[0]);
                    void'(qb.pop_front());
                end
            end
            if (in_valid && in_ready_a) model_accept(in_data);
        end
    end

    function automatic logic [W-1:0] px(input int mode, input int i);
        logic [DS-1:0] b;
        case (mode)
            0:       return {8'(200 - 7*i), 8'(3*i + 5), 8'(i)};
            1:       begin b = 8'(i - 128); return {b, b, b}; end
            2:       return {(i % 2 == 1) ? 8'h7F : 8'h80, 8'h80, 8'($urandom)};
            default: return W'($urandom);
        endcase
    endfunction

    task automatic drive_pixels(input int first, input int last, input int mode,
                                input int vp, input int rp);
        logic [W-1:0] d;
        bit accepted;
        int budget;
        for (int i = first; i <= last; i++) begin
            d        = px(mode, i);
            accepted = 0;
            budget   = 0;
            while (!accepted) begin
                @(posedge clk);
                #1;
                in_valid  = ($urandom_range(99) < vp);
                in_data   = d;
                out_ready = ($urandom_range(99) < rp);
                @(negedge clk);
                accepted = in_valid && in_ready_a;
                budget++;
                if (!accepted && budget > 500) begin
                    fail_now("input_accept_timeout");
                    return;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Called right after the edge that accepted a window-completing pixel.
    task automatic stall(input int n);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = px(0, 9);
        repeat (n) begin
            @(negedge clk);
            check("stall_out_valid", out_valid_a, 1);
            check("stall_in_ready", in_ready_a, 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic do_reset(input int n);
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid_a", out_valid_a, 0);
        check("reset_out_data_a", out_data_a, 0);
        check("reset_frame_done_a", frame_done_a, 0);
        check("reset_out_valid_b", out_valid_b, 0);
        check("reset_out_data_b", out_data_b, 0);

        drive_pixels(0, NPIX-1, 0, 100, 100);   // ascending raster
        drive_pixels(0, NPIX-1, 1, 100, 100);   // all-negative frame
        drive_pixels(0, NPIX-1, 2, 100, 100);   // 0x80 / 0x7F lane isolation

        drive_pixels(0, 8, 0, 100, 100);        // pixel 8 completes the first window
        stall(10);
        drive_pixels(9, NPIX-1, 0, 100, 100);

        for (int f = 0; f < 3; f++) drive_pixels(0, NPIX-1, 3, 70, 60);

        drive_pixels(0, 6, 0, 100, 100);
        do_reset(2);
        @(negedge clk);
        check("post_reset_out_valid_a", out_valid_a, 0);
        check("post_reset_out_valid_b", out_valid_b, 0);
        drive_pixels(0, NPIX-1, 0, 100, 100);

        out_ready = 1'b1;
        in_valid  = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("pending_a", qa.size(), 0);
        check("pending_b", qb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
